// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and decode helpers for the load/store alignment unit.
package lsu_pkg;

  localparam int unsigned F3_WIDTH = 3;
  localparam int unsigned BE_WIDTH = 4;

  localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
  localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
  localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
  localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
  localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} lsu_state_t;

  // Request fields kept after accept; only the byte offset is needed downstream.
  typedef struct packed {
    logic                we;
    logic [F3_WIDTH-1:0] funct3;
    logic [1:0]          addr_lsb;
  } lsu_req_t;

  function automatic logic [BE_WIDTH-1:0] byte_enable(input logic [F3_WIDTH-1:0] funct3,
                                                      input logic [1:0] addr_lsb);
    logic [BE_WIDTH-1:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr_lsb;
      F3_H, F3_HU: be = addr_lsb[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_legal(input logic we, input logic [F3_WIDTH-1:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [F3_WIDTH-1:0] funct3,
                                         input logic [1:0] addr_lsb);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lsb[0];
      F3_W:        mis = |addr_lsb;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Selects the addressed lane of a returned memory word and sign/zero extends it.
module lsu_load_format
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [F3_WIDTH-1:0] funct3,
  input  logic [1:0]          addr_lsb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   rdata_c
);

  logic [DATA_W-1:0] lane_c;

  always_comb begin
    lane_c  = mem_rdata >> {addr_lsb, 3'b000};
    rdata_c = lane_c;
    case (funct3)
      F3_B:    rdata_c = {{(DATA_W-8){lane_c[7]}}, lane_c[7:0]};
      F3_H:    rdata_c = {{(DATA_W-16){lane_c[15]}}, lane_c[15:0]};
      F3_BU:   rdata_c = {{(DATA_W-8){1'b0}}, lane_c[7:0]};
      F3_HU:   rdata_c = {{(DATA_W-16){1'b0}}, lane_c[15:0]};
      default: rdata_c = lane_c;
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// RV32 load/store alignment stage: one request per handshake, word-aligned memory
// access with byte enables, formatted load response, fault flags without memory access.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [F3_WIDTH-1:0]   req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  rsp_illegal
);

  lsu_state_t state, state_d;
  lsu_req_t   req_q;

  logic                  accept_c;
  logic                  illegal_c;
  logic                  misaligned_c;
  logic [DATA_W-1:0]     fmt_rdata_c;
  logic [DATA_W-1:0]     store_data_c;
  logic [DM_ADDRESS-1:0] mem_addr_d;
  logic                  mem_re_d;
  logic                  mem_we_d;
  logic [BE_WIDTH-1:0]   mem_be_d;
  logic [DATA_W-1:0]     mem_wdata_d;
  logic                  rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_d;
  logic                  rsp_misaligned_d;
  logic                  rsp_illegal_d;

  assign req_ready = (state == IDLE);

  lsu_load_format #(.DATA_W(DATA_W)) u_load_format (
    .funct3    (req_q.funct3),
    .addr_lsb  (req_q.addr_lsb),
    .mem_rdata (mem_rdata),
    .rdata_c   (fmt_rdata_c)
  );

  // Illegal funct3 takes priority over misalignment.
  always_comb begin
    illegal_c    = !is_legal(req_we, req_funct3);
    misaligned_c = !illegal_c && is_misaligned(req_funct3, req_addr[1:0]);
    case (req_funct3)
      F3_B:    store_data_c = {4{req_wdata[7:0]}};
      F3_H:    store_data_c = {2{req_wdata[15:0]}};
      default: store_data_c = req_wdata;
    endcase
  end

  // Next state and next registered outputs; strobes and bus fields default to zero.
  always_comb begin
    state_d          = state;
    accept_c         = 1'b0;
    mem_addr_d       = '0;
    mem_re_d         = 1'b0;
    mem_we_d         = 1'b0;
    mem_be_d         = '0;
    mem_wdata_d      = '0;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = '0;
    rsp_misaligned_d = 1'b0;
    rsp_illegal_d    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (illegal_c || misaligned_c) begin
            rsp_valid_d      = 1'b1;
            rsp_illegal_d    = illegal_c;
            rsp_misaligned_d = misaligned_c;
            state_d          = RESP;
          end else begin
            mem_addr_d  = {req_addr[DM_ADDRESS-1:2], 2'b00};
            mem_we_d    = req_we;
            mem_re_d    = !req_we;
            mem_be_d    = byte_enable(req_funct3, req_addr[1:0]);
            mem_wdata_d = req_we ? store_data_c : '0;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = fmt_rdata_c;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_q          <= '0;
      mem_addr       <= '0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= '0;
      mem_wdata      <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
    end else begin
      state          <= state_d;
      mem_addr       <= mem_addr_d;
      mem_re         <= mem_re_d;
      mem_we         <= mem_we_d;
      mem_be         <= mem_be_d;
      mem_wdata      <= mem_wdata_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_misaligned <= rsp_misaligned_d;
      rsp_illegal    <= rsp_illegal_d;
      if (accept_c) begin
        req_q <= '{we: req_we, funct3: req_funct3, addr_lsb: req_addr[1:0]};
      end
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Randomized self-checking bench for lsu_align_unit against a byte-level memory model.
module tb_lsu_align_unit;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_misaligned;
  logic          rsp_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [128] = '{default: 32'h0};
  logic [7:0]  ref_mem [512] = '{default: 8'h0};

  always #5 clk = ~clk;

  lsu_align_unit #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned), .rsp_illegal(rsp_illegal)
  );

  // Synchronous data memory: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [8:0] addr);
    return (int'(addr) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [8:0] addr);
    logic [31:0] v = '0;
    int n = acc_size(f3);
    for (int k = 0; k < n; k++) v |= 32'(ref_mem[int'(addr) + k]) << (8 * k);
    if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [8:0] addr);
    logic [3:0] be = '0;
    for (int k = 0; k < acc_size(f3); k++) be[(int'(addr) + k) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % acc_size(f3)) +: 8];
    return r;
  endfunction

  // Issue one request starting at a negedge; returns after the post-response idle check.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                        input logic [31:0] wd, output logic [31:0] got);
    bit legal, mis, fault, done;
    int lat, exp_lat, n_re, n_we;
    logic [31:0] exp_rd, s_wd;
    logic [8:0] s_addr;
    logic [3:0] s_be;
    legal   = m_legal(we, f3);
    mis     = legal && m_mis(f3, addr);
    fault   = !legal || mis;
    exp_lat = fault ? 1 : (we ? 2 : 3);
    exp_rd  = (fault || we) ? 32'h0 : m_load(f3, addr);
    lat = 0; n_re = 0; n_we = 0; done = 0; got = 32'hx;
    s_addr = '0; s_be = '0; s_wd = '0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (mem_we) begin n_we++; s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata; end
      if (mem_re) begin n_re++; s_addr = mem_addr; end
      if (!mem_re && !mem_we)
        chk("idle_bus", 32'(mem_addr) | 32'(mem_be) | mem_wdata, 32'h0);
      if (rsp_valid) begin
        lat = c; got = rsp_rdata; done = 1;
        chk("rsp_illegal", 32'(rsp_illegal), 32'(!legal));
        chk("rsp_misaligned", 32'(rsp_misaligned), 32'(mis));
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_rdata", got, exp_rd);
    chk("n_we", 32'(n_we), 32'(!fault && we));
    chk("n_re", 32'(n_re), 32'(!fault && !we));
    if (!fault) chk("mem_addr", 32'(s_addr), 32'({addr[8:2], 2'b00}));
    if (!fault && we) begin
      chk("mem_be", 32'(s_be), 32'(m_be(f3, addr)));
      chk("mem_wdata", s_wd, m_wdata(f3, wd));
      for (int k = 0; k < acc_size(f3); k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
    end
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got, rd1, rd2;
    int r1, r2, acc2;
    bit drop;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", 32'({mem_re, mem_we, rsp_valid, rsp_misaligned, rsp_illegal}), 32'd0);
    chk("rst_bus", 32'(mem_addr) | 32'(mem_be) | mem_wdata | rsp_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, got);
    do_req(1'b1, 3'b000, 9'h013, 32'h000000A5, got);
    do_req(1'b1, 3'b001, 9'h016, 32'h00001234, got);
    do_req(1'b1, 3'b010, 9'h020, 32'h80FF7F01, got);
    do_req(1'b0, 3'b000, 9'h021, 32'h0, got); chk("lb_21", got, 32'h0000007F);
    do_req(1'b0, 3'b000, 9'h022, 32'h0, got); chk("lb_22", got, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 9'h023, 32'h0, got); chk("lbu_23", got, 32'h00000080);
    do_req(1'b0, 3'b001, 9'h022, 32'h0, got); chk("lh_22", got, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 9'h022, 32'h0, got); chk("lhu_22", got, 32'h000080FF);
    do_req(1'b0, 3'b010, 9'h020, 32'h0, got); chk("lw_20", got, 32'h80FF7F01);
    do_req(1'b0, 3'b010, 9'h022, 32'h0, got);
    do_req(1'b1, 3'b001, 9'h011, 32'h5555, got);
    do_req(1'b0, 3'b011, 9'h020, 32'h0, got);
    do_req(1'b1, 3'b100, 9'h010, 32'h1, got);
    do_req(1'b0, 3'b011, 9'h021, 32'h0, got);

    // Reset during a store's ACCESS cycle drops it silently.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h040; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_we", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    // Back-to-back loads with req_valid held high.
    r1 = 0; r2 = 0; acc2 = 0; drop = 0; rd1 = '0; rd2 = '0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h020;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (drop) req_valid = 1'b0;
      if (c == 1) begin req_funct3 = 3'b100; req_addr = 9'h023; end
      if (rsp_valid && r1 == 0) begin r1 = c; rd1 = rsp_rdata; end
      else if (rsp_valid && r2 == 0) begin r2 = c; rd2 = rsp_rdata; end
      if (req_ready && req_valid && acc2 == 0) begin acc2 = c; drop = 1; end
    end
    req_valid = 1'b0;
    chk("b2b_rsp1_cycle", 32'(r1), 32'd3);
    chk("b2b_accept2", 32'(acc2), 32'(r1 + 1));
    chk("b2b_rsp2_cycle", 32'(r2), 32'd7);
    chk("b2b_rdata1", rd1, m_load(3'b010, 9'h020));
    chk("b2b_rdata2", rd2, 32'h00000080);

    // Fill memory with random words, then mixed random traffic.
    for (int w = 0; w < 128; w++) do_req(1'b1, 3'b010, 9'(w * 4), $urandom, got);
    for (int t = 0; t < 300; t++) begin
      logic [2:0] f3;
      logic [8:0] a;
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom);
      a  = 9'($urandom);
      if ($urandom_range(0, 1) == 0) a = a & ~9'(acc_size(f3) - 1);
      do_req(1'($urandom), f3, a, $urandom, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
